// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core pipeline controller: next-PC select
// encodings, the trap sequencer state type and default fetch vectors.
package core_ctrl_pkg;

    localparam logic [1:0] PCSEL_SEQ  = 2'd0;
    localparam logic [1:0] PCSEL_BR   = 2'd1;
    localparam logic [1:0] PCSEL_TRAP = 2'd2;

    localparam logic [31:0] RESET_VECTOR        = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the instruction in ID reads a register that a
// load currently in EX has not yet produced. Register x0 never hazards.
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memtoreg,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // Match each live source operand against the pending load destination
    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use = ex_memtoreg && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller: stall/flush generation for the pipeline
// registers, next-PC selection, and the trap flush/redirect sequencer.
module pipe_hazard_ctrl
    import core_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memtoreg,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        mem_invalid,
    input  logic [31:0] mem_pc_plus4,
    input  logic        mem_busy,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_stall,
    output logic        exmem_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic [1:0]  pc_sel,
    output logic [31:0] pc_target,
    output logic [31:0] epc,
    output logic [7:0]  trap_count,
    output logic        trap_active
);

    // The counter starts one below the flush length so that the state is
    // left on the cycle the counter reads zero.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    ctrl_state_t state;
    logic [3:0]  flush_cnt;
    logic        load_use;
    logic        trap_take;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_memtoreg (ex_memtoreg),
        .load_use    (load_use)
    );

    // A trap is only accepted once the memory stage is no longer busy
    assign trap_take   = (state == ST_RUN) && mem_invalid && !mem_busy;
    assign trap_active = (state != ST_RUN);

    // Same-cycle control decode: trap > busy > taken branch > load-use
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_sel      = PCSEL_SEQ;
        pc_target   = 32'd0;
        case (state)
            ST_RUN: begin
                if (trap_take) begin
                    exmem_flush = 1'b1;
                    idex_flush  = 1'b1;
                    ifid_flush  = 1'b1;
                    pc_stall    = 1'b1;
                end else if (mem_busy) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                end else if (ex_branch_taken) begin
                    pc_sel     = PCSEL_BR;
                    pc_target  = ex_branch_target;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            ST_FLUSH: begin
                exmem_flush = 1'b1;
                idex_flush  = 1'b1;
                ifid_flush  = 1'b1;
                pc_stall    = 1'b1;
            end
            ST_REDIRECT: begin
                pc_sel     = PCSEL_TRAP;
                pc_target  = TRAP_VECTOR;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Trap sequencer: record EPC and count on entry, drain, then redirect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            flush_cnt  <= 4'd0;
            epc        <= RESET_VECTOR;
            trap_count <= 8'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (trap_take) begin
                        epc       <= mem_pc_plus4 - 32'd4;
                        flush_cnt <= FLUSH_INIT;
                        state     <= ST_FLUSH;
                        if (trap_count != 8'hFF) begin
                            trap_count <= trap_count + 8'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state <= ST_REDIRECT;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle RUN
// vectors followed by hand-written trap, busy, reset and saturation runs.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_uses_rs1 = 1'b0;
    logic        id_uses_rs2 = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_memtoreg = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_target = '0;
    logic        mem_invalid = 1'b0;
    logic [31:0] mem_pc_plus4 = '0;
    logic        mem_busy = 1'b0;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target;
    logic [31:0] epc;
    logic [7:0]  trap_count;
    logic        trap_active;

    typedef struct {
        string       name;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  exrd;
        logic        m2r;
        logic        br;
        logic [31:0] tgt;
        logic        inv;
        logic        busy;
        logic [31:0] pc4;
        logic [3:0]  stalls;
        logic [2:0]  flushes;
        logic [1:0]  sel;
        logic [31:0] ptgt;
        logic        act;
    } vec_t;

    typedef struct {
        string       name;
        logic [41:0] val;
    } exp_t;

    exp_t exp_q[$];
    vec_t table_v[10];
    int   total  = 0;
    int   passed = 0;

    pipe_hazard_ctrl #(
        .TRAP_VECTOR  (32'h0000_0100),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs1      (id_uses_rs1),
        .id_uses_rs2      (id_uses_rs2),
        .ex_rd            (ex_rd),
        .ex_memtoreg      (ex_memtoreg),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .mem_invalid      (mem_invalid),
        .mem_pc_plus4     (mem_pc_plus4),
        .mem_busy         (mem_busy),
        .pc_stall         (pc_stall),
        .ifid_stall       (ifid_stall),
        .idex_stall       (idex_stall),
        .exmem_stall      (exmem_stall),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .pc_sel           (pc_sel),
        .pc_target        (pc_target),
        .epc              (epc),
        .trap_count       (trap_count),
        .trap_active      (trap_active)
    );

    // Free-running core clock
    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input string name,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2,
        input logic [4:0] exrd, input logic m2r,
        input logic br, input logic [31:0] tgt,
        input logic inv, input logic busy, input logic [31:0] pc4,
        input logic [3:0] stalls, input logic [2:0] flushes,
        input logic [1:0] sel, input logic [31:0] ptgt, input logic act);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exrd = exrd; v.m2r = m2r; v.br = br; v.tgt = tgt;
        v.inv = inv; v.busy = busy; v.pc4 = pc4;
        v.stalls = stalls; v.flushes = flushes; v.sel = sel;
        v.ptgt = ptgt; v.act = act;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        id_rs1           = v.rs1;
        id_rs2           = v.rs2;
        id_uses_rs1      = v.u1;
        id_uses_rs2      = v.u2;
        ex_rd            = v.exrd;
        ex_memtoreg      = v.m2r;
        ex_branch_taken  = v.br;
        ex_branch_target = v.tgt;
        mem_invalid      = v.inv;
        mem_busy         = v.busy;
        mem_pc_plus4     = v.pc4;
        e.name = v.name;
        e.val  = {v.stalls, v.flushes, v.sel, v.ptgt, v.act};
        exp_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [41:0] act;
        total++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
            e   = exp_q.pop_front();
            act = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                   ifid_flush, idex_flush, exmem_flush,
                   pc_sel, pc_target, trap_active};
            if (act === e.val) begin
                passed++;
            end else begin
                $display("[TB] FAIL %s: got %h required %h", e.name, act, e.val);
            end
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
        total++;
        if (actual === required) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h required %h", name, actual, required);
        end
    endtask

    // Drive one cycle of inputs just after the edge, compare mid-cycle
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        applyStimulus(v);
        #4;
        checkOutput();
    endtask

    vec_t idle_v;

    initial begin
        idle_v = mkVec("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       4'b0000, 3'b000, 2'd0, 32'h0, 1'b0);

        table_v[0] = mkVec("tbl_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                           4'b0000, 3'b000, 2'd0, 32'h0, 1'b0);
        table_v[1] = mkVec("tbl_loaduse_rs1", 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0,
                           4'b1100, 3'b010, 2'd0, 32'h0, 1'b0);
        table_v[2] = mkVec("tbl_loaduse_x0", 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0,
                           4'b0000, 3'b000, 2'd0, 32'h0, 1'b0);
        table_v[3] = mkVec("tbl_loaduse_rs2", 3, 7, 1, 1, 7, 1, 0, 0, 0, 0, 0,
                           4'b1100, 3'b010, 2'd0, 32'h0, 1'b0);
        table_v[4] = mkVec("tbl_rs2_unused", 3, 7, 1, 0, 7, 1, 0, 0, 0, 0, 0,
                           4'b0000, 3'b000, 2'd0, 32'h0, 1'b0);
        table_v[5] = mkVec("tbl_not_load", 5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0,
                           4'b0000, 3'b000, 2'd0, 32'h0, 1'b0);
        table_v[6] = mkVec("tbl_branch_over_lu", 5, 0, 1, 0, 5, 1, 1, 32'h40, 0, 0, 0,
                           4'b0000, 3'b110, 2'd1, 32'h40, 1'b0);
        table_v[7] = mkVec("tbl_busy_branch", 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 1, 0,
                           4'b1111, 3'b000, 2'd0, 32'h0, 1'b0);
        table_v[8] = mkVec("tbl_busy_invalid", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h50,
                           4'b1111, 3'b000, 2'd0, 32'h0, 1'b0);
        table_v[9] = mkVec("tbl_busy_loaduse", 5, 0, 1, 0, 5, 1, 0, 0, 0, 1, 0,
                           4'b1111, 3'b000, 2'd0, 32'h0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset_epc", epc, 32'h0);
        checkValue("reset_trap_count", {24'd0, trap_count}, 32'h0);
        reset_n = 1'b1;
        step(idle_v);

        // Single-cycle RUN decode vectors
        for (int i = 0; i < 10; i++) begin
            step(table_v[i]);
        end

        // Trap: entry, two flush cycles (inputs ignored), redirect, back to RUN
        step(mkVec("trap_entry", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h24,
                   4'b1000, 3'b111, 2'd0, 32'h0, 1'b0));
        step(mkVec("trap_flush1", 0, 0, 0, 0, 0, 0, 1, 32'h44, 1, 1, 32'h24,
                   4'b1000, 3'b111, 2'd0, 32'h0, 1'b1));
        checkValue("trap_epc", epc, 32'h20);
        checkValue("trap_count_1", {24'd0, trap_count}, 32'd1);
        step(mkVec("trap_flush2", 0, 0, 0, 0, 0, 0, 1, 32'h44, 1, 1, 32'h24,
                   4'b1000, 3'b111, 2'd0, 32'h0, 1'b1));
        step(mkVec("trap_redirect", 0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 1, 0,
                   4'b0000, 3'b110, 2'd2, 32'h100, 1'b1));
        step(mkVec("trap_back_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   4'b0000, 3'b000, 2'd0, 32'h0, 1'b0));

        // Busy masks a pending trap until it drops
        for (int i = 0; i < 3; i++) begin
            step(mkVec("busy_mask", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h80,
                       4'b1111, 3'b000, 2'd0, 32'h0, 1'b0));
        end
        step(mkVec("busy_drop_trap", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80,
                   4'b1000, 3'b111, 2'd0, 32'h0, 1'b0));

        // Reset asserted in the first flush cycle
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        applyStimulus(mkVec("flush_before_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                            4'b1000, 3'b111, 2'd0, 32'h0, 1'b1));
        #4;
        checkOutput();
        checkValue("busy_trap_epc", epc, 32'h7C);
        checkValue("busy_trap_count", {24'd0, trap_count}, 32'd2);
        step(mkVec("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   4'b0000, 3'b000, 2'd0, 32'h0, 1'b0));
        checkValue("mid_flush_reset_epc", epc, 32'h0);
        checkValue("mid_flush_reset_count", {24'd0, trap_count}, 32'h0);
        reset_n = 1'b1;

        // Back-to-back traps: one every FLUSH_CYCLES+2 cycles, PC+4 of 0 wraps EPC
        @(posedge clk);
        #1;
        mem_invalid  = 1'b1;
        mem_busy     = 1'b0;
        mem_pc_plus4 = 32'h0;
        repeat (1017) @(posedge clk);
        #1;
        checkValue("sat_count_255", {24'd0, trap_count}, 32'd255);
        repeat (4) @(posedge clk);
        #1;
        checkValue("sat_count_hold", {24'd0, trap_count}, 32'd255);
        checkValue("sat_active", {31'd0, trap_active}, 32'd1);
        checkValue("wrap_epc", epc, 32'hFFFF_FFFC);
        mem_invalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkValue("sat_back_run", {31'd0, trap_active}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
